// File: rtl/rob.sv
// -----------------------------------------------------------------------------
// rob -- reorder buffer for the out-of-order core.
//
// A circular queue of in-flight instructions. Decode/rename allocates an entry
// at the tail and receives its rob_id; results arrive over the common data bus
// (CDB); entries retire in program order from the head through the commit port,
// which feeds the register alias table and the register file. Two
// combinational operand lookups let rename read a producer's result early.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   alloc_req           decode requests a new entry this cycle
//   alloc_rd_wr         instruction writes a destination register
//   alloc_rd_addr       destination architectural register
//   alloc_ready         an entry is free (ROB not full)
//   alloc_rob_id        id handed to the allocating instruction (tail)
//   cdb_valid           result broadcast this cycle
//   cdb_rob_id          entry being completed
//   cdb_data            result value
//   rs1_rob_id/rs2_*    producer ids to look up
//   rs1_rdy/rs2_rdy     producer result available (stored or on the CDB)
//   rs1_data/rs2_data   producer result value
//   commit              head entry retires this cycle
//   commit_rob_id       id of the retiring entry (always the head)
//   commit_rd_wr        retiring entry writes a nonzero register
//   commit_rd_addr      destination of the retiring entry
//   commit_data         value to write back
//   count               number of occupied entries
// -----------------------------------------------------------------------------
module rob #(
  parameter int ROB_DEPTH = 16,
  parameter int ROB_PTR_W = $clog2(ROB_DEPTH),
  parameter int DATA_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst,

  input  logic                 alloc_req,
  input  logic                 alloc_rd_wr,
  input  logic [4:0]           alloc_rd_addr,
  output logic                 alloc_ready,
  output logic [ROB_PTR_W-1:0] alloc_rob_id,

  input  logic                 cdb_valid,
  input  logic [ROB_PTR_W-1:0] cdb_rob_id,
  input  logic [DATA_W-1:0]    cdb_data,

  input  logic [ROB_PTR_W-1:0] rs1_rob_id,
  output logic                 rs1_rdy,
  output logic [DATA_W-1:0]    rs1_data,
  input  logic [ROB_PTR_W-1:0] rs2_rob_id,
  output logic                 rs2_rdy,
  output logic [DATA_W-1:0]    rs2_data,

  output logic                 commit,
  output logic [ROB_PTR_W-1:0] commit_rob_id,
  output logic                 commit_rd_wr,
  output logic [4:0]           commit_rd_addr,
  output logic [DATA_W-1:0]    commit_data,

  output logic [ROB_PTR_W:0]   count
);

  localparam logic [ROB_PTR_W:0] FULL_COUNT = (ROB_PTR_W + 1)'(ROB_DEPTH);

  logic [ROB_PTR_W-1:0] head;
  logic [ROB_PTR_W-1:0] tail;

  // Per-entry control bits live in vectors so reset can clear them at once;
  // the payload arrays never need resetting because valid gates every use.
  logic [ROB_DEPTH-1:0] valid;
  logic [ROB_DEPTH-1:0] done;
  logic                 rd_wr_mem   [ROB_DEPTH];
  logic [4:0]           rd_addr_mem [ROB_DEPTH];
  logic [DATA_W-1:0]    data_mem    [ROB_DEPTH];

  logic alloc_fire;
  logic cdb_write;

  // Full is judged from the registered count only: a commit in the same
  // cycle does not open a slot for a same-cycle allocation.
  assign alloc_ready  = (count != FULL_COUNT);
  assign alloc_rob_id = tail;
  assign alloc_fire   = alloc_req && alloc_ready;

  // Results aimed at entries that are not in flight are dropped.
  assign cdb_write = cdb_valid && valid[cdb_rob_id];

  // Commit looks only at registered state, so a CDB write to the head becomes
  // committable on the following cycle.
  assign commit         = valid[head] && done[head];
  assign commit_rob_id  = head;
  assign commit_rd_wr   = rd_wr_mem[head] && (rd_addr_mem[head] != 5'd0);
  assign commit_rd_addr = rd_addr_mem[head];
  assign commit_data    = data_mem[head];

  // Control state. Statement order matters for the head entry: a CDB write
  // to the entry being retired must not leave it marked done. The allocation
  // index can never equal the commit index because allocation is blocked
  // when the queue is full (the only case where head == tail with a valid head).
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      valid <= '0;
      done  <= '0;
    end else begin
      if (cdb_write) begin
        done[cdb_rob_id] <= 1'b1;
      end
      if (commit) begin
        valid[head] <= 1'b0;
        done[head]  <= 1'b0;
        head        <= head + 1'b1;
      end
      if (alloc_fire) begin
        valid[tail] <= 1'b1;
        done[tail]  <= 1'b0;
        tail        <= tail + 1'b1;
      end
      case ({alloc_fire, commit})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage.
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      rd_wr_mem[tail]   <= alloc_rd_wr;
      rd_addr_mem[tail] <= alloc_rd_addr;
    end
    if (cdb_write) begin
      data_mem[cdb_rob_id] <= cdb_data;
    end
  end

  // Operand lookup. A result on the CDB this cycle is forwarded ahead of the
  // stored copy; an entry that is committing this cycle is still valid here.
  logic rs1_cdb_hit;
  logic rs2_cdb_hit;

  assign rs1_cdb_hit = cdb_valid && (cdb_rob_id == rs1_rob_id) && valid[rs1_rob_id];
  assign rs2_cdb_hit = cdb_valid && (cdb_rob_id == rs2_rob_id) && valid[rs2_rob_id];

  assign rs1_rdy  = (valid[rs1_rob_id] && done[rs1_rob_id]) || rs1_cdb_hit;
  assign rs2_rdy  = (valid[rs2_rob_id] && done[rs2_rob_id]) || rs2_cdb_hit;
  assign rs1_data = rs1_cdb_hit ? cdb_data : data_mem[rs1_rob_id];
  assign rs2_data = rs2_cdb_hit ? cdb_data : data_mem[rs2_rob_id];

endmodule
